// File: rtl/event_injector_if.sv
// Event source bus: one timestamped event per valid/ready handshake.
interface event_injector_if #(
    parameter int DATA_W  = 64,
    parameter int DELTA_W = 32
);
    logic                     ev_valid;
    logic                     ev_ready;
    logic [DELTA_W-1:0]       ev_delta;
    logic [1:0]               ev_present;
    logic signed [DATA_W-1:0] ev_data_0;
    logic signed [DATA_W-1:0] ev_data_1;

    modport master (
        output ev_valid, ev_delta, ev_present, ev_data_0, ev_data_1,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_delta, ev_present, ev_data_0, ev_data_1,
        output ev_ready
    );
endinterface

// File: rtl/event_injector.sv
// event_injector: buffers timestamped events and replays them as one-cycle
// new_input_k strobes on the monitor's input streams, spaced by each event's
// delta measured from the previous emission.
// Optional build macro EVENT_INJECTOR_HOLD_VALUE_EN: input_k keeps the last
// value emitted on stream k instead of returning to 0 between emissions.
module event_injector #(
    parameter int DATA_W  = 64,
    parameter int DELTA_W = 32,
    parameter int DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    event_injector_if.slave           ev,
    output logic signed [DATA_W-1:0]  input_0,
    output logic                      new_input_0,
    output logic signed [DATA_W-1:0]  input_1,
    output logic                      new_input_1,
    output logic [$clog2(DEPTH):0]    pending,
    output logic                      busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [DELTA_W-1:0] delta;
        logic [1:0]         present;
        logic [DATA_W-1:0]  data_0;
        logic [DATA_W-1:0]  data_1;
    } event_t;

    typedef enum logic [1:0] {IDLE, WAIT, EMIT} state_t;

    state_t             state_q, state_d;
    event_t             mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [PW-1:0]      count, count_nxt;
    logic [DELTA_W-1:0] since;
    logic               rdy_q;
    logic [1:0]         new_q;
    logic [DATA_W-1:0]  in0_q, in1_q;

    event_t             head, wr_ev;
    logic               full, head_vld, push, fire, gap_ok;
    logic [DELTA_W:0]   eff_delta, since_p1;

    assign full     = (count == PW'(DEPTH));
    assign head_vld = (count != '0);
    assign head     = mem[rd_ptr];

    // A zero delta behaves like one: the earliest slot is the next cycle.
    assign eff_delta = (head.delta == '0) ? (DELTA_W+1)'(1) : {1'b0, head.delta};
    assign since_p1  = {1'b0, since} + (DELTA_W+1)'(1);
    assign gap_ok    = (since_p1 >= eff_delta);

    // rdy_q keeps ev_ready low until the first edge after reset releases.
    assign ev.ev_ready = en & ~full & rdy_q;
    assign push        = ev.ev_valid & ev.ev_ready;
    assign fire        = en & head_vld & gap_ok;
    assign count_nxt   = count + PW'(push) - PW'(fire);

    assign wr_ev.delta   = ev.ev_delta;
    assign wr_ev.present = ev.ev_present;
    assign wr_ev.data_0  = ev.ev_data_0;
    assign wr_ev.data_1  = ev.ev_data_1;

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_ev;
    end

    // FIFO pointers, occupancy and the post-reset ready qualifier.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (fire) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
        end
    end

    // Cycles since the last emission, saturating so a long idle never wraps.
    always_ff @(posedge clk) begin
        if (rst)
            since <= '0;
        else if (en) begin
            if (fire)
                since <= '0;
            else if (~&since)
                since <= since + DELTA_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: EMIT marks the strobe cycle; it can repeat back to back.
    always_comb begin
        state_d = state_q;
        if (en) begin
            if (fire)
                state_d = EMIT;
            else if (count_nxt != '0)
                state_d = WAIT;
            else
                state_d = IDLE;
        end
    end

    // Registered stream outputs, loaded from the head on the emission edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            new_q <= '0;
            in0_q <= '0;
            in1_q <= '0;
        end else if (fire) begin
            new_q <= head.present;
`ifdef EVENT_INJECTOR_HOLD_VALUE_EN
            if (head.present[0]) in0_q <= head.data_0;
            if (head.present[1]) in1_q <= head.data_1;
`else
            in0_q <= head.present[0] ? head.data_0 : '0;
            in1_q <= head.present[1] ? head.data_1 : '0;
`endif
        end else begin
            new_q <= '0;
`ifndef EVENT_INJECTOR_HOLD_VALUE_EN
            in0_q <= '0;
            in1_q <= '0;
`endif
        end
    end

    assign new_input_0 = new_q[0];
    assign new_input_1 = new_q[1];
    assign input_0     = in0_q;
    assign input_1     = in1_q;
    assign pending     = count;
    assign busy        = (count != '0) | (state_q == EMIT);
endmodule

// File: doc/event_injector.md
# event_injector

Stimulus-side counterpart of the generated monitor's input interface. Buffers timestamped input events from a valid/ready source and replays them onto the monitor's `input_k`/`new_input_k` pairs. Each event drives one-cycle `new_input` pulses at a programmed cycle spacing. Sits between a host/trace loader and the monitor top entity, replacing hand-written stimulus sequences.

## Interface
- `DATA_W`, 64: width of each signed input value.
- `DELTA_W`, 32: width of the inter-event gap field.
- `DEPTH`, 4: event FIFO depth; power of two, ≥2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: global enable; low freezes all state.
- `ev_valid` in 1: source offers an event.
- `ev_ready` out 1: block accepts the event this cycle.
- `ev_delta` in DELTA_W: cycles from previous emission to this one.
- `ev_present` in 2: bit k set means stream k receives a new value.
- `ev_data_0` in DATA_W signed: value for stream 0.
- `ev_data_1` in DATA_W signed: value for stream 1.
- `input_0` out DATA_W signed: value to monitor stream 0.
- `new_input_0` out 1: one-cycle strobe, stream 0.
- `input_1` out DATA_W signed: value to monitor stream 1.
- `new_input_1` out 1: one-cycle strobe, stream 1.
- `pending` out log2(DEPTH)+1: events currently buffered.
- `busy` out 1: FIFO non-empty or emission in progress.

## Operation
**Accept**
- An event is pushed when `ev_valid & ev_ready` at a rising edge.
- `ev_ready = en & !full`.
- No push-through when full: a pop frees a slot, and `ev_ready` rises the following cycle.

**Gap counter**
- `since` (DELTA_W bits, saturating at all-ones) is cleared to 0 on reset.
- It is cleared to 0 on each emission edge.
- Otherwise it increments by 1 each enabled cycle.

**States**
- IDLE: FIFO empty. Goes to WAIT on the first push.
- WAIT: head present. Goes to EMIT when `since + 1 >= max(head.delta, 1)`.
- EMIT: one cycle, and the head is popped. Then goes to WAIT if the FIFO is still non-empty, else IDLE.
- Effective delta is `max(delta, 1)`. Delta 0 and delta 1 both allow back-to-back emission on consecutive cycles.

**Outputs (registered)**
- In the EMIT cycle: `new_input_k = head.present[k]`.
- In the EMIT cycle: `input_k = head.present[k] ? head.data_k : 0`.
- Outside EMIT: both strobes are 0, and `input_k` follows the Configuration section.
- `ev_present = 00` is a silent tick. It consumes a gap slot and resets `since`, but raises no strobes.

**Enable and reset**
- `en` low: no push, no pop, `since` holds, state holds, strobes forced 0.
- `rst` mid-operation: FIFO flushed, state IDLE, `since = 0`.
- Reset values of every output: `new_input_k = 0`, `input_k = 0`, `pending = 0`, `busy = 0`, `ev_ready = 0`. `ev_ready` goes to 1 the cycle after `rst` deasserts with `en` high.

## Timing
- Accept at edge N into an empty FIFO with the gap satisfied: strobes are high in cycle N+1 to N+2, i.e. 2-edge minimum latency.
- Gap rule: if emission E_i occurs at edge T and E_{i+1} has effective delta d, E_{i+1} strobes at edge T+d, provided it was accepted by edge T+d−2.
- Each strobe lasts exactly one cycle.
- `pending` updates on the push/pop edge. A simultaneous push and pop leaves `pending` unchanged.
- `busy` is registered and equals `pending != 0 | strobe active`.

## Configuration
- `EVENT_INJECTOR_HOLD_VALUE_EN`
- Defined: `input_k` retains the last value emitted on stream k until that stream's next emission. Silent ticks and non-present streams do not alter it.
- Undefined: `input_k` is 0 in every non-EMIT cycle, and 0 for non-present streams in EMIT.
- Reset clears held values in both builds.

## Test plan
- Single event: push delta=5, present=11, data=(1,1) right after reset → one strobe on both streams with `input = (1,1)`, then `(0,0)`; `pending` goes 1→0.
- Spacing: push deltas 1000, 1000, 2000 with data 1, 2, 3 → strobes exactly 1000 and 2000 cycles apart; values match.
- Back-to-back: push deltas 0, 1, 1 → strobes on three consecutive cycles.
- Full FIFO: push 5 events with delta 100 and `DEPTH=4` → `ev_ready` low after the 4th push; the 5th is accepted the cycle after the first emission; the order is preserved.
- Silent tick and mask: present=01, then 00, then 10 with delta 3 each → only `new_input_0`, then no strobes, then only `new_input_1`, at 3-cycle spacing.
- `en` and reset: drop `en` for 10 cycles during WAIT → emission delayed by exactly 10 cycles. Assert `rst` with 3 events pending → no strobes afterward and `pending = 0`. Rerun the mask test with `EVENT_INJECTOR_HOLD_VALUE_EN` defined → `input_0` holds its last value.
